// File: rtl/gray_pkg.sv
// Shared types, defaults and helpers for the Gray-code counter family.
package gray_pkg;

    localparam int unsigned GRAY_WIDTH_DEFAULT = 4;
    localparam int unsigned DIV_DEFAULT        = 1;
    localparam int unsigned GRAY_MAX_WIDTH     = 16;

    // Reference 4-bit Gray sequence indexed by binary value.
    localparam logic [3:0] GRAY4_TABLE [16] = '{
        4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
        4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8
    };

    // Reflected binary Gray encode at the widest supported width; callers
    // zero-extend narrower values and truncate the result.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_encode.sv
// Purely combinational binary-to-Gray encoder.
module gray_encode
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Zero-extend, encode, truncate: upper zero bits never reach the low WIDTH bits.
    always_comb begin
        gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin)));
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with prescaler, synchronous load and registered Gray/binary outputs.
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH    = GRAY_WIDTH_DEFAULT,
    parameter int unsigned STEP_DIV = DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             upd,
    output logic             tc
);

    if (WIDTH < 2 || WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
        $error("gray_counter: WIDTH out of range 2..16");
    end
    if (STEP_DIV < 1 || STEP_DIV > 256) begin : g_bad_div
        $error("gray_counter: STEP_DIV out of range 1..256");
    end

    // Keep at least one prescaler bit so STEP_DIV=1 still elaborates cleanly.
    localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             upd_q, upd_d;
    logic             tc_q, tc_d;

    // Next-state: load beats step, step beats hold.
    always_comb begin
        bin_d   = bin_q;
        presc_d = presc_q;
        upd_d   = 1'b0;
        tc_d    = 1'b0;
        if (load) begin
            bin_d   = load_bin;
            presc_d = '0;
            upd_d   = 1'b1;
        end else if (en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                upd_d   = 1'b1;
                if (up_dn) begin
                    bin_d = bin_q + WIDTH'(1);
                    tc_d  = (bin_q == '1);
                end else begin
                    bin_d = bin_q - WIDTH'(1);
                    tc_d  = (bin_q == '0);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Encode the next binary value so both registers load on the same edge.
    gray_encode #(
        .WIDTH (WIDTH)
    ) u_encode (
        .bin  (bin_d),
        .gray (gray_d)
    );

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            gray_q  <= '0;
            presc_q <= '0;
            upd_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            presc_q <= presc_d;
            upd_q   <= upd_d;
            tc_q    <= tc_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign upd      = upd_q;
    assign tc       = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: vector table, scoreboard model and corner sequences.
module tb_gray_counter;
    import gray_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, up_dn = 1'b0, load = 1'b0;
    logic [3:0] load_bin = 4'h0;
    logic [3:0] gray_out, bin_out;
    logic       upd, tc;

    logic       d3_en = 1'b0, d3_up = 1'b1, d3_load = 1'b0;
    logic [3:0] d3_load_bin = 4'h0;
    logic [3:0] d3_gray, d3_bin;
    logic       d3_upd, d3_tc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4), .STEP_DIV(1)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_bin (load_bin),
        .gray_out (gray_out),
        .bin_out  (bin_out),
        .upd      (upd),
        .tc       (tc)
    );

    gray_counter #(.WIDTH(4), .STEP_DIV(3)) u_div3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (d3_en),
        .up_dn    (d3_up),
        .load     (d3_load),
        .load_bin (d3_load_bin),
        .gray_out (d3_gray),
        .bin_out  (d3_bin),
        .upd      (d3_upd),
        .tc       (d3_tc)
    );

    typedef struct {
        logic [3:0] bin;
        logic [3:0] gray;
        logic       upd;
        logic       tc;
    } exp_t;

    typedef struct {
        logic       en;
        logic       up_dn;
        logic       load;
        logic [3:0] load_bin;
        logic [3:0] exp_bin;
        logic [3:0] exp_gray;
        logic       exp_upd;
        logic       exp_tc;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[23];
    logic [3:0] m_bin = 4'h0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return g2b_ret(b);
    endfunction

    function automatic logic [3:0] g2b_ret(input logic [3:0] b);
        return b;
    endfunction

    // Reference model for the STEP_DIV=1 instance; gray taken from the table.
    function automatic exp_t model(input logic e, input logic u, input logic ld,
                                   input logic [3:0] lb);
        exp_t r;
        r.bin = m_bin; r.upd = 1'b0; r.tc = 1'b0;
        if (ld) begin
            r.bin = lb; r.upd = 1'b1;
        end else if (e) begin
            r.upd = 1'b1;
            if (u) begin r.bin = m_bin + 4'd1; r.tc = (m_bin == 4'hF); end
            else   begin r.bin = m_bin - 4'd1; r.tc = (m_bin == 4'h0); end
        end
        r.gray = GRAY4_TABLE[r.bin];
        return r;
    endfunction

    // Drive one cycle, push the expectation, then pop and compare after the edge.
    task automatic drive_cycle(input logic e, input logic u, input logic ld,
                               input logic [3:0] lb, input exp_t x, input string tag);
        exp_t got;
        en = e; up_dn = u; load = ld; load_bin = lb;
        sb.push_back(x);
        m_bin = x.bin;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            chk({tag, ".bin"},  {12'h0, bin_out},  {12'h0, got.bin});
            chk({tag, ".gray"}, {12'h0, gray_out}, {12'h0, got.gray});
            chk({tag, ".upd"},  {15'h0, upd},      {15'h0, got.upd});
            chk({tag, ".tc"},   {15'h0, tc},       {15'h0, got.tc});
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        en = 0; load = 0; d3_en = 0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_bin = 4'h0;
    endtask

    initial begin
        exp_t x;
        logic [3:0] prev_gray;
        logic       e, u, ld;
        logic [3:0] lb;
        int         pulses;
        logic       d3_pat [14] = '{1,1,1,1,1,1,1,1,1, 1,0,0,1,1};
        logic       d3_upd_exp [14] = '{0,0,1,0,0,1,0,0,1, 0,0,0,0,1};
        logic [3:0] d3_bin_exp [14] = '{0,0,1,1,1,2,2,2,3, 3,3,3,3,4};

        // en, up, load, load_bin, bin, gray, upd, tc
        vecs[0]  = '{1,1,0,4'h0, 4'h1,4'h1,1,0};
        vecs[1]  = '{1,1,0,4'h0, 4'h2,4'h3,1,0};
        vecs[2]  = '{1,1,0,4'h0, 4'h3,4'h2,1,0};
        vecs[3]  = '{1,1,0,4'h0, 4'h4,4'h6,1,0};
        vecs[4]  = '{1,1,0,4'h0, 4'h5,4'h7,1,0};
        vecs[5]  = '{1,1,0,4'h0, 4'h6,4'h5,1,0};
        vecs[6]  = '{1,1,0,4'h0, 4'h7,4'h4,1,0};
        vecs[7]  = '{1,1,0,4'h0, 4'h8,4'hC,1,0};
        vecs[8]  = '{1,1,0,4'h0, 4'h9,4'hD,1,0};
        vecs[9]  = '{1,1,0,4'h0, 4'hA,4'hF,1,0};
        vecs[10] = '{1,1,0,4'h0, 4'hB,4'hE,1,0};
        vecs[11] = '{1,1,0,4'h0, 4'hC,4'hA,1,0};
        vecs[12] = '{1,1,0,4'h0, 4'hD,4'hB,1,0};
        vecs[13] = '{1,1,0,4'h0, 4'hE,4'h9,1,0};
        vecs[14] = '{1,1,0,4'h0, 4'hF,4'h8,1,0};
        vecs[15] = '{1,1,0,4'h0, 4'h0,4'h0,1,1};
        vecs[16] = '{1,0,0,4'h0, 4'hF,4'h8,1,1};
        vecs[17] = '{1,0,0,4'h0, 4'hE,4'h9,1,0};
        vecs[18] = '{1,0,0,4'h0, 4'hD,4'hB,1,0};
        vecs[19] = '{1,1,1,4'hA, 4'hA,4'hF,1,0};
        vecs[20] = '{1,1,0,4'h0, 4'hB,4'hE,1,0};
        vecs[21] = '{0,1,0,4'h0, 4'hB,4'hE,0,0};
        vecs[22] = '{0,0,1,4'hB, 4'hB,4'hE,1,0};

        // Reset state, checked while reset is held and before any edge.
        #2;
        chk("reset.bin",  {12'h0, bin_out},  16'h0);
        chk("reset.gray", {12'h0, gray_out}, 16'h0);
        chk("reset.upd",  {15'h0, upd},      16'h0);
        chk("reset.tc",   {15'h0, tc},       16'h0);
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            x.bin = vecs[i].exp_bin; x.gray = vecs[i].exp_gray;
            x.upd = vecs[i].exp_upd; x.tc   = vecs[i].exp_tc;
            drive_cycle(vecs[i].en, vecs[i].up_dn, vecs[i].load, vecs[i].load_bin, x,
                        $sformatf("vec%0d", i));
        end

        // Async reset mid-count at bin=7.
        do_reset();
        for (int i = 0; i < 7; i++) drive_cycle(1, 1, 0, 4'h0, model(1, 1, 0, 4'h0), "pre_rst");
        chk("mid.bin7", {12'h0, bin_out}, 16'h7);
        en = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.bin",  {12'h0, bin_out},  16'h0);
        chk("async.gray", {12'h0, gray_out}, 16'h0);
        chk("async.upd",  {15'h0, upd},      16'h0);
        #1;
        rst_n = 1'b1;
        m_bin = 4'h0;
        x.bin = 4'h1; x.gray = 4'h1; x.upd = 1'b1; x.tc = 1'b0;
        drive_cycle(1, 1, 0, 4'h0, x, "post_rst");

        // Prescaler with STEP_DIV=3, including a two-cycle enable gap.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            d3_en = d3_pat[i];
            @(posedge clk);
            #1;
            if (i < 9 && d3_upd) pulses++;
            chk($sformatf("div3.upd%0d", i), {15'h0, d3_upd}, {15'h0, d3_upd_exp[i]});
            chk($sformatf("div3.bin%0d", i), {12'h0, d3_bin}, {12'h0, d3_bin_exp[i]});
            chk($sformatf("div3.gray%0d", i), {12'h0, d3_gray},
                {12'h0, GRAY4_TABLE[d3_bin_exp[i]]});
        end
        chk("div3.pulses", 16'(pulses), 16'd3);
        d3_en = 0;

        // Randomised chain check against an inline Gray-to-binary decoder.
        do_reset();
        prev_gray = 4'h0;
        for (int i = 0; i < 1000; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1) == 1;
            ld = ($urandom_range(0, 15) == 0);
            lb = 4'($urandom_range(0, 15));
            drive_cycle(e, u, ld, lb, model(e, u, ld, lb), "rand");
            chk("chain.decode", {12'h0, g2b(gray_out)}, {12'h0, bin_out});
            if (upd && !ld)
                chk("chain.onebit", 16'($countones(gray_out ^ prev_gray)), 16'd1);
            prev_gray = gray_out;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parameterised up/down counter with registered Gray-code output; the source stage directly upstream of graytobin.
- Holds a binary count internally and presents both Gray and binary forms, so the binary output can check graytobin's decode.
- Supports enable, direction, synchronous load, a one-cycle update strobe and a terminal-count strobe.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.
- STEP_DIV, 1, prescaler: the count advances once every STEP_DIV enabled cycles; legal range 1..256.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable.
- up_dn  in  1  direction: 1 counts up, 0 counts down.
- load  in  1  synchronous load strobe.
- load_bin  in  WIDTH  binary value to load.
- gray_out  out  WIDTH  registered Gray code of the current count.
- bin_out  out  WIDTH  registered binary count.
- upd  out  1  one-cycle pulse: gray_out/bin_out changed this cycle.
- tc  out  1  one-cycle pulse: the last update wrapped.

Behaviour:
- Reset: asynchronous on rst_n low. gray_out=0, bin_out=0, upd=0, tc=0, prescaler=0, all immediately. Release is synchronous to clk; the first count is possible on the first edge after release.
- Gray encoding: gray_out = bin_out ^ (bin_out >> 1), always consistent with bin_out in the same cycle. Both registers update on the same edge; no combinational path from inputs to outputs.
- Priority each edge: load > step > hold.
- Load: bin_out <= load_bin; gray_out <= encode(load_bin); prescaler cleared; upd=1; tc=0. en is ignored that cycle.
- Prescaler: counts enabled cycles 0..STEP_DIV-1. A step happens when en=1 and the prescaler = STEP_DIV-1; the prescaler then returns to 0. With STEP_DIV=1 every enabled cycle is a step. en=0 holds the prescaler value; it is not cleared.
- Step up: bin_out <= bin_out+1, modulo 2^WIDTH.
- Step down: bin_out <= bin_out-1, modulo 2^WIDTH.
- upd=1 on every step.
- tc=1 only on a step that wraps: up from 2^WIDTH-1 to 0, or down from 0 to 2^WIDTH-1.
- Latency: step or load input sampled at edge N is visible on the outputs after edge N; upd/tc are high for exactly the cycle after edge N.
- Non-step cycles: upd=0 and tc=0; outputs hold.
- Direction change: takes effect on the next step with no extra delay; prescaler state is kept.
- Load equal to the current value: upd still pulses; outputs are unchanged.
- Reset mid-count: all state cleared immediately; the counter resumes from 0.
- Invariant: consecutive gray_out values separated by a step differ in exactly one bit, including across wrap.

Decomposition:
- Package gray_pkg:
  - function bin2gray(logic [WIDTH-1:0]).
  - localparams GRAY_WIDTH_DEFAULT=4 and DIV_DEFAULT=1.
  - 4-bit reference Gray table constant, for bench use.
- Sub-module gray_encode: purely combinational binary-to-Gray, WIDTH-parameterised. It is instantiated on the next-state binary value so the Gray register loads in the same edge as the binary register.
- Prescaler stays inline; it is too small for its own module.

Test Plan:
- Reset and up-count, WIDTH=4, STEP_DIV=1, up_dn=1, en=1 for 16 cycles:
  - gray_out = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8 then back to 0.
  - tc=1 only on the F→0 binary wrap cycle; upd=1 every cycle.
- Down-count from 0, up_dn=0, en=1:
  - bin_out = F,E,D…; gray_out = 8,9,B…
  - tc=1 on the first step (0→F).
- Load priority: load=1, load_bin=A, en=1 in the same cycle → bin_out=A, gray_out=F, upd=1, tc=0; the next step gives bin_out=B, gray_out=E.
- Prescaler, STEP_DIV=3, en=1 for 9 cycles → exactly 3 upd pulses, each on every 3rd cycle. Dropping en for 2 cycles mid-way only delays the next pulse by 2 cycles.
- Async reset mid-count: at bin_out=7, pull rst_n low between edges → outputs read 0 before the next edge. After release, the next step gives gray_out=1.
- Chain check with graytobin on gray_out, WIDTH=4, random en/up_dn/load for 1000 cycles:
  - graytobin op == bin_out every cycle.
  - Single-bit Gray change on every upd cycle that is not a load.
